// File: rtl/rat_ckpt_pkg.sv
// -----------------------------------------------------------------------------
// rat_ckpt_pkg
// Shared configuration and types for the checkpointing register alias table.
// Holds the default build parameters and the types used to talk about
// physical register tags, whole map tables and checkpoint ids.
// -----------------------------------------------------------------------------
package rat_ckpt_pkg;

    localparam int DEF_SS        = 2;   // rename slots per cycle
    localparam int DEF_ARCH_REGS = 32;  // architectural registers, x0 hardwired
    localparam int DEF_PHYS_REGS = 64;  // physical registers
    localparam int DEF_NUM_CKPT  = 4;   // checkpoints, power of 2

    localparam int DEF_AR_W = $clog2(DEF_ARCH_REGS);
    localparam int DEF_PR_W = $clog2(DEF_PHYS_REGS);
    localparam int DEF_CK_W = $clog2(DEF_NUM_CKPT);

    typedef logic [DEF_AR_W-1:0]      ar_t;
    typedef logic [DEF_PR_W-1:0]      pr_t;
    typedef pr_t [DEF_ARCH_REGS-1:0]  rat_map_t;
    typedef logic [DEF_CK_W-1:0]      ckpt_id_t;

endpackage

// File: rtl/rat_ckpt_if.sv
// -----------------------------------------------------------------------------
// rat_ckpt_if
// Rename / checkpoint / resolve bus between the rename stage and the RAT.
//   master : rename stage + branch unit (drives requests, reads mappings)
//   slave  : rat_ckpt (answers lookups, reports checkpoint availability)
// Signals:
//   ren_valid, isa_rd/rs1/rs2, rat_rd   per-slot rename request
//   rat_rs1/rs2, rat_old_rd             per-slot renamed operands
//   ckpt_req, ckpt_slot                 snapshot request, last slot included
//   ckpt_ready, ckpt_id                 free entry exists, id of next snapshot
//   res_valid, res_id, res_mispredict   branch resolution
// -----------------------------------------------------------------------------
interface rat_ckpt_if
    import rat_ckpt_pkg::*;
#(
    parameter int SS        = DEF_SS,
    parameter int ARCH_REGS = DEF_ARCH_REGS,
    parameter int PHYS_REGS = DEF_PHYS_REGS,
    parameter int NUM_CKPT  = DEF_NUM_CKPT
);
    localparam int AR_W = $clog2(ARCH_REGS);
    localparam int PR_W = $clog2(PHYS_REGS);
    localparam int CK_W = $clog2(NUM_CKPT);
    localparam int SL_W = (SS > 1) ? $clog2(SS) : 1;

    logic [SS-1:0]            ren_valid;
    logic [SS-1:0][AR_W-1:0]  isa_rd;
    logic [SS-1:0][AR_W-1:0]  isa_rs1;
    logic [SS-1:0][AR_W-1:0]  isa_rs2;
    logic [SS-1:0][PR_W-1:0]  rat_rd;
    logic [SS-1:0][PR_W-1:0]  rat_rs1;
    logic [SS-1:0][PR_W-1:0]  rat_rs2;
    logic [SS-1:0][PR_W-1:0]  rat_old_rd;

    logic                     ckpt_req;
    logic [SL_W-1:0]          ckpt_slot;
    logic                     ckpt_ready;
    logic [CK_W-1:0]          ckpt_id;

    logic                     res_valid;
    logic [CK_W-1:0]          res_id;
    logic                     res_mispredict;

    modport master (
        output ren_valid, isa_rd, isa_rs1, isa_rs2, rat_rd,
        output ckpt_req, ckpt_slot,
        output res_valid, res_id, res_mispredict,
        input  rat_rs1, rat_rs2, rat_old_rd,
        input  ckpt_ready, ckpt_id
    );

    modport slave (
        input  ren_valid, isa_rd, isa_rs1, isa_rs2, rat_rd,
        input  ckpt_req, ckpt_slot,
        input  res_valid, res_id, res_mispredict,
        output rat_rs1, rat_rs2, rat_old_rd,
        output ckpt_ready, ckpt_id
    );

endinterface

// File: rtl/rat_bypass.sv
// -----------------------------------------------------------------------------
// rat_bypass
// Combinational intra-group forwarding for the rename bundle.
// Ports:
//   i_map              committed-to-rename map table (state before this group)
//   i_valid, i_rd      per-slot valid and architectural destination
//   i_rs1, i_rs2       per-slot architectural sources
//   i_prd              per-slot newly allocated physical destination
//   o_rs1, o_rs2       renamed sources (x0 reads 0)
//   o_old_rd           prior mapping of each destination (x0 reads 0)
//   o_after[k]         map table with the writes of slots 0..k applied
// Slot i looks up in o_after[i-1], which already holds the youngest older
// write to every register, so the "highest j < i" rule falls out for free.
// -----------------------------------------------------------------------------
module rat_bypass #(
    parameter int SS        = 2,
    parameter int ARCH_REGS = 32,
    parameter int PR_W      = 6,
    parameter int AR_W      = $clog2(ARCH_REGS)
) (
    input  logic [ARCH_REGS-1:0][PR_W-1:0]          i_map,
    input  logic [SS-1:0]                           i_valid,
    input  logic [SS-1:0][AR_W-1:0]                 i_rd,
    input  logic [SS-1:0][AR_W-1:0]                 i_rs1,
    input  logic [SS-1:0][AR_W-1:0]                 i_rs2,
    input  logic [SS-1:0][PR_W-1:0]                 i_prd,
    output logic [SS-1:0][PR_W-1:0]                 o_rs1,
    output logic [SS-1:0][PR_W-1:0]                 o_rs2,
    output logic [SS-1:0][PR_W-1:0]                 o_old_rd,
    output logic [SS-1:0][ARCH_REGS-1:0][PR_W-1:0]  o_after
);
    typedef logic [ARCH_REGS-1:0][PR_W-1:0] map_t;

    map_t w_cur;

    // Apply the slot writes in program order; x0 is never written so
    // physical register 0 stays bound to it.
    always_comb begin
        // NOTE: every variable gets a full default before the loop so no
        // path leaves it unassigned and no latch is inferred.
        w_cur   = i_map;
        o_after = '0;
        for (int k = 0; k < SS; k++) begin
            // NOTE: blocking assignments here are deliberate: each slot must
            // see the writes of the older slots made earlier in this loop.
            if (i_valid[k] && (i_rd[k] != '0)) begin
                w_cur[i_rd[k]] = i_prd[k];
            end
            o_after[k] = w_cur;
        end
    end

    for (genvar i = 0; i < SS; i++) begin : g_slot
        map_t w_base;

        if (i == 0) begin : g_first
            assign w_base = i_map;
        end else begin : g_rest
            assign w_base = o_after[i-1];
        end

        assign o_rs1[i]    = (i_rs1[i] == '0) ? '0 : w_base[i_rs1[i]];
        assign o_rs2[i]    = (i_rs2[i] == '0) ? '0 : w_base[i_rs2[i]];
        assign o_old_rd[i] = (i_rd[i]  == '0) ? '0 : w_base[i_rd[i]];
    end

endmodule

// File: rtl/rat_ckpt.sv
// -----------------------------------------------------------------------------
// rat_ckpt
// Superscalar register alias table with branch checkpoints.
// Ports:
//   clk   clock
//   rst   synchronous reset, active low
//   bus   rat_ckpt_if.slave: rename lookups/updates, checkpoint allocation,
//         branch resolution (release or restore)
// Checkpoints form a ring [head, tail) of count live entries. Correct
// resolves mark an entry done; the head retires one done entry per cycle so
// out-of-order resolves drain in order. A mispredict restores the map from
// the resolved snapshot and frees it together with every younger entry; it
// overrides same-cycle renames, allocation and head retirement.
// -----------------------------------------------------------------------------
module rat_ckpt
    import rat_ckpt_pkg::*;
#(
    parameter int SS        = DEF_SS,
    parameter int ARCH_REGS = DEF_ARCH_REGS,
    parameter int PHYS_REGS = DEF_PHYS_REGS,
    parameter int NUM_CKPT  = DEF_NUM_CKPT
) (
    input  logic      clk,
    input  logic      rst,
    rat_ckpt_if.slave bus
);
    localparam int AR_W = $clog2(ARCH_REGS);
    localparam int PR_W = $clog2(PHYS_REGS);
    localparam int CK_W = $clog2(NUM_CKPT);

    localparam logic [CK_W:0]   CNT_FULL = (CK_W+1)'(NUM_CKPT);
    localparam logic [CK_W:0]   CNT_ONE  = (CK_W+1)'(1);
    localparam logic [CK_W-1:0] ID_ONE   = CK_W'(1);

    typedef logic [ARCH_REGS-1:0][PR_W-1:0] map_t;

    map_t                                    r_map;
    map_t                                    r_snap [NUM_CKPT];
    logic [NUM_CKPT-1:0]                     r_done;
    logic [CK_W-1:0]                         r_head;
    logic [CK_W-1:0]                         r_tail;
    logic [CK_W:0]                           r_count;

    logic [SS-1:0][ARCH_REGS-1:0][PR_W-1:0]  w_after;
    logic [CK_W-1:0]                         w_res_off;
    logic                                    w_res_live;
    logic                                    w_has_room;
    logic                                    w_mispredict;
    logic                                    w_release;
    logic                                    w_alloc;
    logic                                    w_retire;

    rat_bypass #(
        .SS        (SS),
        .ARCH_REGS (ARCH_REGS),
        .PR_W      (PR_W),
        .AR_W      (AR_W)
    ) u_bypass (
        .i_map    (r_map),
        .i_valid  (bus.ren_valid),
        .i_rd     (bus.isa_rd),
        .i_rs1    (bus.isa_rs1),
        .i_rs2    (bus.isa_rs2),
        .i_prd    (bus.rat_rd),
        .o_rs1    (bus.rat_rs1),
        .o_rs2    (bus.rat_rs2),
        .o_old_rd (bus.rat_old_rd),
        .o_after  (w_after)
    );

    // Age of the resolved id relative to head; it is live only if that age
    // is below count. The same age is the surviving count on a mispredict.
    assign w_res_off    = bus.res_id - r_head;
    assign w_res_live   = ({1'b0, w_res_off} < r_count);
    assign w_has_room   = (r_count < CNT_FULL);

    assign w_mispredict = bus.res_valid &&  bus.res_mispredict && w_res_live;
    assign w_release    = bus.res_valid && !bus.res_mispredict && w_res_live;
    assign w_alloc      = bus.ckpt_req && w_has_room && !w_mispredict;
    assign w_retire     = (r_count != '0) && r_done[r_head] && !w_mispredict;

    assign bus.ckpt_ready = w_has_room;
    assign bus.ckpt_id    = r_tail;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_map[i] <= PR_W'(i);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_done  <= '0;
        end else if (w_mispredict) begin
            r_map   <= r_snap[bus.res_id];
            r_tail  <= bus.res_id;
            r_count <= {1'b0, w_res_off};
        end else begin
            r_map <= w_after[SS-1];
            if (w_alloc) begin
                r_done[r_tail] <= 1'b0;
                r_tail         <= r_tail + ID_ONE;
            end
            // A live res_id never equals tail while allocation is possible,
            // so this cannot collide with the clear above.
            if (w_release) begin
                r_done[bus.res_id] <= 1'b1;
            end
            if (w_retire) begin
                r_head <= r_head + ID_ONE;
            end
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: ;
            endcase
        end
    end

    // NOTE: snapshot storage is deliberately left without reset; an entry is
    // only read after it has been written by an allocation.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_snap[r_tail] <= w_after[bus.ckpt_slot];
        end
    end

    // Protocol checks: the hardware tolerates both cases by ignoring the
    // request, but upstream is expected never to produce them.
    a_no_req_when_full : assert property (
        @(posedge clk) disable iff (!rst) !(bus.ckpt_req && !w_has_room)
    ) else $warning("rat_ckpt: ckpt_req while no checkpoint is free, dropped");

    a_res_id_live : assert property (
        @(posedge clk) disable iff (!rst) bus.res_valid |-> w_res_live
    ) else $warning("rat_ckpt: resolve of a checkpoint that is not live, ignored");

endmodule
